// File: rtl/gf180mcu_osu_sc_ro_meas_pkg.sv
// ============================================================================
// Module : gf180mcu_osu_sc_ro_meas_pkg
// Brief  : Shared types and constants for the ring-oscillator frequency meter.
//          Build macro: GF180MCU_OSU_SC_RO_MEAS_SYNC3_EN selects a 3-flop RO synchronizer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gf180mcu_osu_sc_ro_meas_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;

`ifdef GF180MCU_OSU_SC_RO_MEAS_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/gf180mcu_osu_sc_12T_sync.sv
// ============================================================================
// Module : gf180mcu_osu_sc_12T_sync
// Brief  : Multi-flop synchronizer bringing the free-running RO into CLK.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_osu_sc_12T_sync
    import gf180mcu_osu_sc_ro_meas_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic CLK,
    input  logic RN,
    input  logic D,
    output logic Q
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], D};
        end
    end

    assign Q = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/gf180mcu_osu_sc_12t_ro_meas.sv
// ============================================================================
// Module : gf180mcu_osu_sc_12t_ro_meas
// Brief  : Counts rising RO edges over a programmable window of CLK cycles.
//          Build macro: GF180MCU_OSU_SC_RO_MEAS_SYNC3_EN (3-flop synchronizer).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_osu_sc_12t_ro_meas
    import gf180mcu_osu_sc_ro_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             RO,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    output logic [CNT_W-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             ro_sync;
    logic             ro_prev_q;
    logic             ro_rise;

    gf180mcu_osu_sc_12T_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .CLK (CLK),
        .RN  (RN),
        .D   (RO),
        .Q   (ro_sync)
    );

    assign ro_rise = ro_sync & ~ro_prev_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Clearing on acceptance means ARM already presents a clean result.
                if (START) begin
                    state_d = ST_ARM;
                    win_d   = WINDOW;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ARM: begin
                state_d = (win_q != '0) ? ST_MEASURE : ST_DONE;
            end
            ST_MEASURE: begin
                win_d = win_q - 1'b1;
                if (ro_rise) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (win_q == WIN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ro_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ro_prev_q <= ro_sync;
        end
    end

    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign BUSY  = (state_q == ST_ARM) || (state_q == ST_MEASURE);
    assign DONE  = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_osu_sc_12t_ro_meas.sv
// ============================================================================
// Module : tb_gf180mcu_osu_sc_12t_ro_meas
// Brief  : Self-checking bench for the RO meter (16-bit and 4-bit counter builds).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_osu_sc_12t_ro_meas;

`ifdef GF180MCU_OSU_SC_RO_MEAS_SYNC3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        CLK    = 1'b0;
    logic        RN     = 1'b1;
    logic        RO     = 1'b0;
    logic        START  = 1'b0;
    logic [15:0] WINDOW = '0;

    logic [15:0] count16;
    logic        busy16, done16, ovf16;
    logic [3:0]  count4;
    logic        busy4, done4, ovf4;

    int   cyc    = 0;
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   ro_hist [0:8191];
    logic ro_val  = 1'b0;
    int   ro_left = 0;
    int   ro_half = 2;

    gf180mcu_osu_sc_12t_ro_meas #(.CNT_W(16), .WIN_W(16)) dut16 (
        .CLK(CLK), .RN(RN), .RO(RO), .START(START), .WINDOW(WINDOW),
        .COUNT(count16), .BUSY(busy16), .DONE(done16), .OVF(ovf16)
    );

    gf180mcu_osu_sc_12t_ro_meas #(.CNT_W(4), .WIN_W(16)) dut4 (
        .CLK(CLK), .RN(RN), .RO(RO), .START(START), .WINDOW(WINDOW),
        .COUNT(count4), .BUSY(busy4), .DONE(done4), .OVF(ovf4)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // RO is a square wave whose half period is ro_half cycles (0 = random 2..5).
    task automatic drive(input logic st, input logic [15:0] w);
        if (RN) begin
            if (ro_left == 0) begin
                ro_val  = ~ro_val;
                ro_left = (ro_half == 0) ? int'($urandom_range(5, 2)) : ro_half;
            end
            ro_left--;
        end else begin
            ro_val = 1'b0;
        end
        RO           = ro_val;
        ro_hist[cyc] = ro_val;
        START        = st;
        WINDOW       = w;
    endtask

    task automatic step(input logic st, input logic [15:0] w);
        @(negedge CLK);
        drive(st, w);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":busy16"},  busy16,  0);
        check({tag, ":done16"},  done16,  0);
        check({tag, ":count16"}, count16, 0);
        check({tag, ":ovf16"},   ovf16,   0);
        check({tag, ":busy4"},   busy4,   0);
        check({tag, ":done4"},   done4,   0);
        check({tag, ":count4"},  count4,  0);
        check({tag, ":ovf4"},    ovf4,    0);
    endtask

    // A rising RO transition seen in cycle c reaches the edge detector LAT cycles
    // later; the measure phase spans cycles n+2 .. n+1+w after START in cycle n.
    task automatic run_meas(input string tag, input int w, input int half,
                            input int extra_k, input int abort_k, output int edges);
        int n;
        ro_half = half;
        @(negedge CLK);
        RN = 1'b1;
        drive(1'b1, w[15:0]);
        n = cyc;
        edges = 0;
        for (int k = 1; k <= w + 4; k++) begin
            step(k == extra_k, 16'($urandom));
            if (k == abort_k) begin
                #2 RN = 1'b0;
                #1 check_zero({tag, ":abort"});
                return;
            end
            check({tag, ":busy16"}, busy16, (k <= w + 1));
            check({tag, ":done16"}, done16, (k >= w + 2));
            check({tag, ":busy4"},  busy4,  (k <= w + 1));
            check({tag, ":done4"},  done4,  (k >= w + 2));
        end
        for (int c = n + 2 - LAT; c <= n + 1 + w - LAT; c++) begin
            if (ro_hist[c] && !ro_hist[c - 1]) edges++;
        end
        check({tag, ":count16"}, count16, (edges > 65535) ? 65535 : edges);
        check({tag, ":ovf16"},   ovf16,   (edges > 65535));
        check({tag, ":count4"},  count4,  (edges > 15) ? 15 : edges);
        check({tag, ":ovf4"},    ovf4,    (edges > 15));
    endtask

    initial begin
        int e;
        int w;
        int h;
        #1 RN = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) step(1'b0, 16'd0);
        check_zero("reset_held");
        @(negedge CLK);
        RN = 1'b1;
        drive(1'b0, 16'd0);
        while (cyc < 9) step(1'b0, 16'd0);

        run_meas("ro_div4_w100", 100, 2, 0, 0, e);
        check("ro_div4_w100:range", (count16 >= 24 && count16 <= 26), 1);

        run_meas("win0", 0, 2, 0, 0, e);
        check("win0:count", count16, 0);

        run_meas("sat_w40", 40, 1, 0, 0, e);
        check("sat_w40:count4", count4, 15);
        check("sat_w40:ovf4", ovf4, 1);
        run_meas("sat_w8", 8, 1, 0, 0, e);
        check("sat_w8:count4", count4, 4);
        check("sat_w8:ovf4", ovf4, 0);

        run_meas("restart_ignored", 100, 2, 40, 0, e);

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(60, 1);
            h = $urandom_range(3, 0);
            h = (h == 0) ? 0 : h + 1;
            run_meas($sformatf("rand%0d", i), w, h,
                     (w >= 2) ? int'($urandom_range(w, 2)) : 0, 0, e);
        end

        run_meas("abort_mid", 100, 2, 0, 50, e);
        repeat (3) step(1'b0, 16'd0);
        check_zero("abort_held");
        run_meas("after_abort_w20", 20, 2, 0, 0, e);
        check("after_abort_w20:range", (count16 >= 4 && count16 <= 6), 1);

        repeat (2) step(1'b0, 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
